// File: rtl/aud_ctrl_pkg.sv
// aud_ctrl_pkg: shared state codes for the audio
// record/playback mode controller.
package aud_ctrl_pkg;

  localparam logic [2:0] ST_CODE_INIT   = 3'd0;
  localparam logic [2:0] ST_CODE_IDLE   = 3'd1;
  localparam logic [2:0] ST_CODE_RECORD = 3'd2;
  localparam logic [2:0] ST_CODE_PLAY   = 3'd3;
  localparam logic [2:0] ST_CODE_PAUSE  = 3'd4;

  typedef enum logic [2:0] {
    ST_INIT   = ST_CODE_INIT,
    ST_IDLE   = ST_CODE_IDLE,
    ST_RECORD = ST_CODE_RECORD,
    ST_PLAY   = ST_CODE_PLAY,
    ST_PAUSE  = ST_CODE_PAUSE
  } state_e;

endpackage

// File: rtl/aud_mode_ctrl_if.sv
// aud_mode_ctrl_if: asynchronous SRAM bus between
// the mode controller (master) and the memory.
interface aud_mode_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we_n;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we_n,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we_n,
    output rdata
  );

endinterface

// File: rtl/aud_time_counter.sv
// aud_time_counter: sample-strobe divider feeding a
// saturating elapsed-seconds counter.
module aud_time_counter #(
  parameter int SAMPLES_PER_SEC = 32000,
  parameter int TIME_W          = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [TIME_W-1:0] o_time
);

  localparam int CNT_W =
    (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(SAMPLES_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divide strobes down to seconds; hold at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r  <= '0;
      o_time <= '0;
    end else if (i_clr) begin
      cnt_r  <= '0;
      o_time <= '0;
    end else if (i_en) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= '0;
        if (!(&o_time))
          o_time <= o_time + TIME_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aud_mode_ctrl.sv
// aud_mode_ctrl: record/playback FSM with SRAM sequencing.
// Define AUD_CTRL_LOOP_EN to make playback wrap at take end.
module aud_mode_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int ADDR_W          = 20,
  parameter int DATA_W          = 16,
  parameter int SAMPLES_PER_SEC = 32000,
  parameter int TIME_W          = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic              i_sample_stb,
  input  logic [DATA_W-1:0] i_rec_data,
  aud_mode_ctrl_if.master   sram,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_play_valid,
  output logic [2:0]        o_state,
  output logic [ADDR_W:0]   o_rec_len,
  output logic [TIME_W-1:0] o_time
);

  state_e state_r, state_n;

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   addr_nx;
  logic [ADDR_W:0]   len_n;
  logic wr_stb, rd_stb;
  logic rec_full, play_end;
  logic addr_clr, len_ld, t_clr;
  logic rd_pend_r;

  assign wr_stb   = i_sample_stb && (state_r == ST_RECORD);
  assign rd_stb   = i_sample_stb && (state_r == ST_PLAY);
  assign addr_nx  = {1'b0, addr_r} + (ADDR_W+1)'(1);
  assign rec_full = wr_stb && (&addr_r);
  assign play_end = rd_stb && (addr_nx == o_rec_len);
  // A strobe landing with stop still counts toward the take
  assign len_n    = wr_stb ? addr_nx : {1'b0, addr_r};
  assign o_state  = state_r;

  // Next state from keys (stop > rec > play) and take end
  always_comb begin
    state_n  = state_r;
    addr_clr = 1'b0;
    t_clr    = 1'b0;
    len_ld   = 1'b0;
    unique case (state_r)
      ST_INIT: begin
        if (i_init_done)
          state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_key_stop) begin
          state_n = ST_IDLE;
        end else if (i_key_rec) begin
          state_n  = ST_RECORD;
          addr_clr = 1'b1;
          t_clr    = 1'b1;
        end else if (i_key_play && (o_rec_len != '0)) begin
          state_n  = ST_PLAY;
          addr_clr = 1'b1;
          t_clr    = 1'b1;
        end
      end
      ST_RECORD: begin
        if (i_key_stop || rec_full) begin
          state_n = ST_IDLE;
          len_ld  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_key_stop) begin
          state_n = ST_IDLE;
        end else if (play_end) begin
`ifdef AUD_CTRL_LOOP_EN
          addr_clr = 1'b1;
          t_clr    = 1'b1;
          if (i_key_play)
            state_n = ST_PAUSE;
`else
          state_n = ST_IDLE;
`endif
        end else if (i_key_play) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_key_stop)
          state_n = ST_IDLE;
        else if (i_key_play)
          state_n = ST_PLAY;
      end
      default: state_n = ST_INIT;
    endcase
  end

  // State, take address counter and committed take length
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_INIT;
      addr_r    <= '0;
      o_rec_len <= '0;
    end else begin
      state_r <= state_n;
      if (addr_clr)
        addr_r <= '0;
      else if (wr_stb || rd_stb)
        addr_r <= addr_nx[ADDR_W-1:0];
      if (len_ld)
        o_rec_len <= len_n;
    end
  end

  // SRAM strobes and two-cycle playback read pipeline
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sram.addr    <= '0;
      sram.wdata   <= '0;
      sram.we_n    <= 1'b1;
      rd_pend_r    <= 1'b0;
      o_play_data  <= '0;
      o_play_valid <= 1'b0;
    end else begin
      sram.we_n    <= ~wr_stb;
      rd_pend_r    <= rd_stb;
      o_play_valid <= rd_pend_r;
      if (wr_stb || rd_stb)
        sram.addr <= addr_r;
      if (wr_stb)
        sram.wdata <= i_rec_data;
      if (rd_pend_r)
        o_play_data <= sram.rdata;
    end
  end

  aud_time_counter #(
    .SAMPLES_PER_SEC(SAMPLES_PER_SEC),
    .TIME_W         (TIME_W)
  ) u_time (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (t_clr),
    .i_en   (wr_stb || rd_stb),
    .o_time (o_time)
  );

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// tb_aud_mode_ctrl: two controller configs (8- and 32-word
// SRAM) driven in lockstep against a behavioural model.
`timescale 1ns/1ps
module tb_aud_mode_ctrl;

  localparam int DW   = 16;
  localparam int SPS  = 4;
  localparam int TW   = 2;
  localparam int TMAX = 3;
  localparam int AW0  = 3;
  localparam int AW1  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic k_rec = 1'b0;
  logic k_play = 1'b0;
  logic k_stop = 1'b0;
  logic stb = 1'b0;
  logic [DW-1:0] rec_d = '0;
  bit fixed = 1'b0;
  bit chk_on = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aud_mode_ctrl_if #(.ADDR_W(AW0), .DATA_W(DW)) s0 ();
  aud_mode_ctrl_if #(.ADDR_W(AW1), .DATA_W(DW)) s1 ();

  logic [DW-1:0] pd0, pd1;
  logic          pv0, pv1;
  logic [2:0]    st0, st1;
  logic [AW0:0]  rl0;
  logic [AW1:0]  rl1;
  logic [TW-1:0] t0, t1;

  aud_mode_ctrl #(
    .ADDR_W(AW0), .DATA_W(DW),
    .SAMPLES_PER_SEC(SPS), .TIME_W(TW)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_init_done(init_done),
    .i_key_rec(k_rec), .i_key_play(k_play),
    .i_key_stop(k_stop), .i_sample_stb(stb),
    .i_rec_data(rec_d), .sram(s0),
    .o_play_data(pd0), .o_play_valid(pv0),
    .o_state(st0), .o_rec_len(rl0), .o_time(t0)
  );

  aud_mode_ctrl #(
    .ADDR_W(AW1), .DATA_W(DW),
    .SAMPLES_PER_SEC(SPS), .TIME_W(TW)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_init_done(init_done),
    .i_key_rec(k_rec), .i_key_play(k_play),
    .i_key_stop(k_stop), .i_sample_stb(stb),
    .i_rec_data(rec_d), .sram(s1),
    .o_play_data(pd1), .o_play_valid(pv1),
    .o_state(st1), .o_rec_len(rl1), .o_time(t1)
  );

  // Asynchronous SRAMs
  logic [DW-1:0] m0 [8];
  logic [DW-1:0] m1 [32];
  initial begin
    for (int i = 0; i < 8; i++) m0[i] = '0;
    for (int i = 0; i < 32; i++) m1[i] = '0;
  end
  always @(posedge clk) begin
    if (!s0.we_n) m0[s0.addr] <= s0.wdata;
    if (!s1.we_n) m1[s1.addr] <= s1.wdata;
  end
  assign s0.rdata = fixed ? (16'(s0.addr) + 16'h100)
                          : m0[s0.addr];
  assign s1.rdata = fixed ? (16'(s1.addr) + 16'h100)
                          : m1[s1.addr];

  logic [31:0] a_st[2], a_addr[2], a_wd[2], a_we[2];
  logic [31:0] a_pd[2], a_pv[2], a_len[2], a_tm[2];
  assign a_st[0]   = 32'(st0);
  assign a_st[1]   = 32'(st1);
  assign a_addr[0] = 32'(s0.addr);
  assign a_addr[1] = 32'(s1.addr);
  assign a_wd[0]   = 32'(s0.wdata);
  assign a_wd[1]   = 32'(s1.wdata);
  assign a_we[0]   = 32'(s0.we_n);
  assign a_we[1]   = 32'(s1.we_n);
  assign a_pd[0]   = 32'(pd0);
  assign a_pd[1]   = 32'(pd1);
  assign a_pv[0]   = 32'(pv0);
  assign a_pv[1]   = 32'(pv1);
  assign a_len[0]  = 32'(rl0);
  assign a_len[1]  = 32'(rl1);
  assign a_tm[0]   = 32'(t0);
  assign a_tm[1]   = 32'(t1);

  // Behavioural model: mode 0..4 as o_state codes,
  // pos = next take index, nstb = strobes since clear.
  int depth[2] = '{8, 32};
  int mst[2], pos[2], len[2], nstb[2];
  int rdp[2], rda[2];
  int e_addr[2], e_wd[2], e_we[2], e_pd[2], e_pv[2];
  int mm[2][32];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++) mm[i][j] = 0;
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; pos[i] = 0; len[i] = 0; nstb[i] = 0;
      rdp[i] = 0; rda[i] = 0;
      e_addr[i] = 0; e_wd[i] = 0; e_we[i] = 1;
      e_pd[i] = 0; e_pv[i] = 0;
    end
  endtask

  task automatic model_step();
    bit fin;
    for (int i = 0; i < 2; i++) begin
      e_we[i] = 1;
      e_pv[i] = 0;
      if (rdp[i] != 0) begin
        e_pv[i] = 1;
        e_pd[i] = fixed ? ((rda[i] + 'h100) & 'hffff)
                        : mm[i][rda[i]];
        rdp[i] = 0;
      end
      case (mst[i])
        0: if (init_done) mst[i] = 1;
        1: begin
          if (k_stop) begin
          end else if (k_rec) begin
            mst[i] = 2; pos[i] = 0; nstb[i] = 0;
          end else if (k_play && len[i] != 0) begin
            mst[i] = 3; pos[i] = 0; nstb[i] = 0;
          end
        end
        2: begin
          if (stb) begin
            e_addr[i] = pos[i];
            e_wd[i] = int'(rec_d);
            e_we[i] = 0;
            mm[i][pos[i]] = int'(rec_d);
            pos[i]++; nstb[i]++;
          end
          if (k_stop || pos[i] == depth[i]) begin
            mst[i] = 1; len[i] = pos[i];
          end
        end
        3: begin
          fin = 1'b0;
          if (stb) begin
            e_addr[i] = pos[i];
            rdp[i] = 1; rda[i] = pos[i];
            pos[i]++; nstb[i]++;
            fin = (pos[i] == len[i]);
          end
          if (k_stop) mst[i] = 1;
          else if (fin) begin
`ifdef AUD_CTRL_LOOP_EN
            pos[i] = 0; nstb[i] = 0;
            if (k_play) mst[i] = 4;
`else
            mst[i] = 1;
`endif
          end else if (k_play) mst[i] = 4;
        end
        4: begin
          if (k_stop) mst[i] = 1;
          else if (k_play) mst[i] = 3;
        end
        default: mst[i] = 0;
      endcase
    end
  endtask

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  logic [DW-1:0] pvq0[$];
  logic [DW-1:0] pvq1[$];

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        int et;
        et = nstb[i] / SPS;
        if (et > TMAX) et = TMAX;
        cmp($sformatf("u%0d_state", i), a_st[i], 32'(mst[i]));
        cmp($sformatf("u%0d_addr", i), a_addr[i], 32'(e_addr[i]));
        cmp($sformatf("u%0d_wdata", i), a_wd[i], 32'(e_wd[i]));
        cmp($sformatf("u%0d_we_n", i), a_we[i], 32'(e_we[i]));
        cmp($sformatf("u%0d_pdata", i), a_pd[i], 32'(e_pd[i]));
        cmp($sformatf("u%0d_pvalid", i), a_pv[i], 32'(e_pv[i]));
        cmp($sformatf("u%0d_reclen", i), a_len[i], 32'(len[i]));
        cmp($sformatf("u%0d_time", i), a_tm[i], 32'(et));
      end
      if (pv0) pvq0.push_back(pd0);
      if (pv1) pvq1.push_back(pd1);
    end
  end

  task automatic step(input bit r, input bit p, input bit s,
                      input bit sb, input logic [DW-1:0] d);
    k_rec = r; k_play = p; k_stop = s;
    stb = sb; rec_d = d;
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0);
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    step(0, 0, 0, 1, d);
    idle(3);
  endtask

  task automatic chk_pvq(input string nm,
                         input logic [DW-1:0] q[$],
                         input int n, input int base);
    cmp({nm, "_count"}, 32'(q.size()), 32'(n));
    for (int k = 0; k < q.size() && k < n; k++)
      cmp($sformatf("%s_%0d", nm, k), 32'(q[k]),
          32'(base + k));
  endtask

  initial begin
    int gap;
    bit r, p, s, sb;
    @(negedge clk);
    #1;
    model_reset();
    chk_on = 1'b1;

    // Reset held with keys pressed, then INIT with keys
    step(1, 1, 0, 1, 16'hdead);
    cmp("reset_state", a_st[0], 32'd0);
    cmp("reset_we_n", a_we[1], 32'd1);
    rst_n = 1'b1;
    step(1, 1, 0, 0, '0);
    step(0, 1, 0, 1, 16'h1234);
    cmp("init_hold", a_st[1], 32'd0);
    init_done = 1'b1;
    step(0, 0, 0, 0, '0);
    cmp("init_to_idle", a_st[0], 32'd1);

    // Five-sample take
    step(1, 0, 0, 0, '0);
    for (int k = 1; k <= 5; k++) strobe(16'(k * 'h11));
    step(0, 0, 1, 0, '0);
    idle(2);
    cmp("take5_len_u0", a_len[0], 32'd5);
    cmp("take5_len_u1", a_len[1], 32'd5);
    cmp("take5_idle", a_st[1], 32'd1);

    // Playback with SRAM returning addr+0x100
    fixed = 1'b1;
    pvq0.delete(); pvq1.delete();
    step(0, 1, 0, 0, '0);
    for (int k = 0; k < 5; k++) strobe('0);
    idle(2);
    chk_pvq("play_u0", pvq0, 5, 'h100);
    chk_pvq("play_u1", pvq1, 5, 'h100);
`ifdef AUD_CTRL_LOOP_EN
    cmp("loop_state", a_st[0], 32'd3);
    step(0, 0, 0, 1, '0);
    cmp("loop_wrap_addr", a_addr[1], 32'd0);
    idle(3);
    step(0, 0, 1, 0, '0);
    idle(1);
`else
    cmp("play_end_idle", a_st[0], 32'd1);
`endif

    // Pause after two reads, strobes ignored, resume
    pvq0.delete(); pvq1.delete();
    step(0, 1, 0, 0, '0);
    strobe('0);
    strobe('0);
    step(0, 1, 0, 0, '0);
    cmp("pause_state", a_st[1], 32'd4);
    for (int k = 0; k < 3; k++) strobe('0);
    cmp("pause_no_valid", 32'(pvq0.size()), 32'd2);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    cmp("resume_addr_u0", a_addr[0], 32'd2);
    cmp("resume_addr_u1", a_addr[1], 32'd2);
    idle(3);
    chk_pvq("resume_u1", pvq1, 3, 'h100);
    step(0, 0, 1, 0, '0);
    idle(1);
    fixed = 1'b0;

    // Long take: u0 fills at 8, u1 tracks seconds
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, k == 19, 1, 16'(16'ha000 + k));
      if (k == 3) cmp("time_1", a_tm[1], 32'd1);
      if (k == 7) begin
        cmp("full_len", a_len[0], 32'd8);
        cmp("full_idle", a_st[0], 32'd1);
        cmp("time_2", a_tm[1], 32'd2);
      end
      if (k == 11) cmp("time_3", a_tm[1], 32'd3);
      idle(3);
    end
    cmp("time_sat", a_tm[1], 32'd3);
    cmp("stop_stb_len", a_len[1], 32'd20);
    cmp("full_len_hold", a_len[0], 32'd8);

    // Randomised keys, strobes, data and resets
    gap = 3;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        init_done = 1'($urandom_range(0, 1));
        step(0, 0, 0, 0, '0);
        rst_n = 1'b1;
        gap = 3;
        continue;
      end
      if (!init_done && $urandom_range(0, 3) == 0)
        init_done = 1'b1;
      r = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 69) == 0);
      sb = (gap >= 3) && ($urandom_range(0, 2) == 0);
      if (sb) gap = 0;
      else gap++;
      step(r, p, s, sb, 16'($urandom));
    end
    idle(4);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aud_mode_ctrl.md
# aud_mode_ctrl

Parametrised record/playback mode controller for the audio synth top level. Replaces the two-state INIT/ACTIVE sequencing with a full INIT/IDLE/RECORD/PLAY/PAUSE state machine. It generates SRAM addresses and strobes, paced by a per-sample strobe. It also records take length, produces the elapsed-time display value, and hands playback samples to the DSP path.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width
- SAMPLES_PER_SEC, 32000, sample strobes per displayed second
- TIME_W, 6, elapsed-time counter width
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_init_done  in  1  codec I2C init finished (level)
- i_key_rec  in  1  record request, one-cycle pulse
- i_key_play  in  1  play / pause toggle, one-cycle pulse
- i_key_stop  in  1  stop request, one-cycle pulse
- i_sample_stb  in  1  one-cycle pulse per audio sample, already synchronised to i_clk
- i_rec_data  in  DATA_W  sample to record, valid with i_sample_stb
- i_sram_rdata  in  DATA_W  SRAM read data (asynchronous SRAM)
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_wdata  out  DATA_W  SRAM write data
- o_sram_we_n  out  1  SRAM write enable, active-low
- o_play_data  out  DATA_W  playback sample
- o_play_valid  out  1  one-cycle pulse, o_play_data updated
- o_state  out  3  INIT=0, IDLE=1, RECORD=2, PLAY=3, PAUSE=4
- o_rec_len  out  ADDR_W+1  samples in last take
- o_time  out  TIME_W  elapsed seconds of current take/playback

## Operation
- INIT -> IDLE when i_init_done=1; all keys ignored in INIT.
- Key priority when simultaneous: stop > rec > play.
- IDLE:
  - rec: go to RECORD; address 0, time 0.
  - play: go to PLAY from address 0 if o_rec_len≠0; otherwise stay in IDLE.
- RECORD: each strobe writes i_rec_data at the current address, then increments the address.
  - stop: go to IDLE; o_rec_len = words written.
  - After writing address 2^ADDR_W−1: auto-go to IDLE, o_rec_len = 2^ADDR_W.
  - play and rec keys are ignored.
- PLAY: each strobe reads the current address, then increments it.
  - After reading address o_rec_len−1: go to IDLE.
  - play: go to PAUSE. stop: go to IDLE. rec is ignored.
- PAUSE: strobes ignored; address and time held. play: back to PLAY. stop: go to IDLE.
- A new RECORD overwrites o_rec_len only when that take ends.
- Time counter:
  - Counts strobes processed in RECORD/PLAY.
  - Every SAMPLES_PER_SEC strobes, o_time increments, saturating at 2^TIME_W−1.
  - Cleared when entering RECORD or PLAY from IDLE.
- A strobe in the same cycle as a key is processed under the current state_r. Example: a sample coinciding with stop is still written and counted in o_rec_len.

## Timing
- Reset values: o_state=INIT, o_sram_addr=0, o_sram_wdata=0, o_sram_we_n=1, o_play_data=0, o_play_valid=0, o_rec_len=0, o_time=0.
- Reset mid-take: everything returns to INIT immediately, o_rec_len included.
- State changes take effect on the clock edge after the key pulse.
- Record write, strobe at cycle N:
  - N+1: o_sram_addr, o_sram_wdata registered; o_sram_we_n=0 for exactly that cycle.
  - Address counter increments at N+1.
- Play read, strobe at cycle N:
  - N+1: o_sram_addr driven; o_sram_we_n stays 1.
  - N+2: i_sram_rdata captured into o_play_data; o_play_valid=1 for one cycle.
- A final-sample read still produces its o_play_valid at N+2, even though the state is already IDLE.
- Strobes arrive at least 4 cycles apart.

## Configuration
- AUD_CTRL_LOOP_EN defined: PLAY wraps at o_rec_len. Address returns to 0, o_time clears, state stays PLAY; only stop leaves.
- AUD_CTRL_LOOP_EN undefined: PLAY ends in IDLE at o_rec_len, as described in Operation.

## Structure
- aud_ctrl_pkg holds:
  - state enum (3-bit encodings above)
  - localparams for state codes used by the top-level LED/o_state mapping
- One sub-module, aud_time_counter:
  - sample-count divider plus saturating seconds counter
  - inputs: clear, enable-strobe
  - parameters: SAMPLES_PER_SEC, TIME_W

## Test plan
- Reset, then i_init_done=1 -> o_state 0 then 1; all outputs at reset values.
- RECORD, 5 strobes with data 0x0011..0x0055, then stop -> we_n pulses at addr 0..4 with matching wdata; o_rec_len=5; state IDLE.
- PLAY after that take, SRAM model returns addr+0x100 -> o_play_valid 5 times, data 0x100..0x104 each 2 cycles after its strobe; then IDLE (LOOP_EN undefined) or addr wraps to 0 (defined).
- PLAY, play pulse after 2 strobes, 3 strobes while paused, play again -> next read at addr 2; no o_play_valid while paused.
- ADDR_W=3 recording, 10 strobes -> auto-IDLE after 8th write, o_rec_len=8; 9th/10th strobes cause no write.
- SAMPLES_PER_SEC=4, TIME_W=2, 20 strobes in RECORD -> o_time 1,2,3 then saturates at 3; stop coinciding with a strobe -> that sample is written and counted.
